// File: rtl/npu_pkg.sv
// Shared NPU definitions used by the tap chain.
//   chain_mode_e : stage0 source selection (SHIFT takes the input vector,
//                  ROTATE recirculates the current tap stage).
//   clamp_len    : maps a programmed length onto 1..depth; 0 or anything
//                  beyond depth selects the full physical chain.
package npu_pkg;

    typedef enum logic {
        SHIFT  = 1'b0,
        ROTATE = 1'b1
    } chain_mode_e;

    function automatic int clamp_len(input int len, input int depth);
        int r;
        if ((len == 0) || (len > depth)) begin
            r = depth;
        end else begin
            r = len;
        end
        return r;
    endfunction

endpackage

// File: rtl/tap_chain_stage.sv
// One stage of the tap chain: LANES x DWIDTH data register plus a valid bit
// shared by all lanes of the stage.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   i_flush    : synchronous clear, wins over i_en
//   i_en       : load i_d / i_dv, otherwise hold
//   i_d, i_dv  : next stage contents
//   o_q, o_qv  : current stage contents
module tap_chain_stage
    import npu_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_en,
    input  logic [DWIDTH-1:0] i_d [0:LANES-1],
    input  logic              i_dv,
    output logic [DWIDTH-1:0] o_q [0:LANES-1],
    output logic              o_qv
);

    logic [DWIDTH-1:0] r_q [0:LANES-1];
    logic              r_qv;

    // Stage register: reset > flush > enable > hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++) begin
                r_q[l] <= '0;
            end
            r_qv <= 1'b0;
        end else if (i_flush) begin
            for (int l = 0; l < LANES; l++) begin
                r_q[l] <= '0;
            end
            r_qv <= 1'b0;
        end else if (i_en) begin
            r_q  <= i_d;
            r_qv <= i_dv;
        end else begin
            r_q  <= r_q;
            r_qv <= r_qv;
        end
    end

    assign o_q  = r_q;
    assign o_qv = r_qv;

endmodule

// File: rtl/tap_chain.sv
// Multi-lane tapped delay chain with per-stage valid, programmable active
// length, rotate (recirculate) mode and synchronous flush.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_en              : advance the chain (0 = hold everything)
//   i_flush           : synchronous clear, priority over i_en
//   i_mode            : 0 = shift in i_data, 1 = rotate tap stage into stage0
//   i_len             : active length; 0 or > DEPTH means DEPTH
//   i_valid, i_data   : input vector and its valid (shift mode only)
//   i_lane_mask       : per-lane take (1) / zero-fill (0)
//   o_data, o_valid   : every stage, visible as taps
//   o_tap_data/valid  : stage Leff-1, combinational from state and i_len
//   o_count           : number of valid stages among 0..Leff-1
module tap_chain
    import npu_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int LENW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_mode,
    input  logic [LENW-1:0]   i_len,
    input  logic              i_valid,
    input  logic [DWIDTH-1:0] i_data      [0:LANES-1],
    input  logic [LANES-1:0]  i_lane_mask,
    output logic [DWIDTH-1:0] o_data      [0:DEPTH-1][0:LANES-1],
    output logic [DEPTH-1:0]  o_valid,
    output logic [DWIDTH-1:0] o_tap_data  [0:LANES-1],
    output logic              o_tap_valid,
    output logic [LENW-1:0]   o_count
);

    logic [LENW-1:0]   w_leff;
    logic [DWIDTH-1:0] w_q        [0:DEPTH-1][0:LANES-1];
    logic [DEPTH-1:0]  w_qv;
    logic [DWIDTH-1:0] w_src_data [0:LANES-1];
    logic              w_src_valid;
    logic [DWIDTH-1:0] w_tap_data [0:LANES-1];
    logic              w_tap_valid;
    logic [LENW-1:0]   w_count;

    assign w_leff = LENW'(clamp_len(int'(i_len), DEPTH));

    // Tap mux: select stage Leff-1 without a bit-width-mismatched array index.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_tap_data[l] = '0;
        end
        w_tap_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == (int'(w_leff) - 1)) begin
                w_tap_data  = w_q[k];
                w_tap_valid = w_qv[k];
            end else begin
                w_tap_valid = w_tap_valid;
            end
        end
    end

    // Occupancy: popcount of valid over the active stages only.
    always_comb begin
        w_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(w_leff)) begin
                w_count = w_count + LENW'(w_qv[k]);
            end else begin
                w_count = w_count;
            end
        end
    end

    // Stage0 source: masked input in shift mode, the tap stage in rotate mode.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_src_data[l] = '0;
        end
        w_src_valid = 1'b0;
        if (chain_mode_e'(i_mode) == ROTATE) begin
            w_src_data  = w_tap_data;
            w_src_valid = w_tap_valid;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                w_src_data[l] = i_lane_mask[l] ? i_data[l] : '0;
            end
            w_src_valid = i_valid;
        end
    end

    // Stages beyond Leff still follow their predecessor; only stage0's source changes.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            tap_chain_stage #(.DWIDTH(DWIDTH), .LANES(LANES)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_flush (i_flush),
                .i_en    (i_en),
                .i_d     (w_src_data),
                .i_dv    (w_src_valid),
                .o_q     (w_q[k]),
                .o_qv    (w_qv[k])
            );
        end else begin : g_rest
            tap_chain_stage #(.DWIDTH(DWIDTH), .LANES(LANES)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_flush (i_flush),
                .i_en    (i_en),
                .i_d     (w_q[k-1]),
                .i_dv    (w_qv[k-1]),
                .o_q     (w_q[k]),
                .o_qv    (w_qv[k])
            );
        end
    end

    assign o_data      = w_q;
    assign o_valid     = w_qv;
    assign o_tap_data  = w_tap_data;
    assign o_tap_valid = w_tap_valid;
    assign o_count     = w_count;

endmodule

// File: tb/tb_tap_chain.sv
// Self-checking bench for tap_chain: directed tables/sequences plus random
// stimulus compared against a queue-style reference model of the chain.
module tb_tap_chain;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int DP = 8;
    localparam int LW = $clog2(DP + 1);

    logic          clk;
    logic          rst;
    logic          i_en;
    logic          i_flush;
    logic          i_mode;
    logic [LW-1:0] i_len;
    logic          i_valid;
    logic [DW-1:0] i_data [0:LN-1];
    logic [LN-1:0] i_lane_mask;
    logic [DW-1:0] o_data [0:DP-1][0:LN-1];
    logic [DP-1:0] o_valid;
    logic [DW-1:0] o_tap_data [0:LN-1];
    logic          o_tap_valid;
    logic [LW-1:0] o_count;

    tap_chain #(.DWIDTH(DW), .LANES(LN), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_flush     (i_flush),
        .i_mode      (i_mode),
        .i_len       (i_len),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_lane_mask (i_lane_mask),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_tap_data  (o_tap_data),
        .o_tap_valid (o_tap_valid),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each stage is a packed LN*DW word plus a valid bit.
    logic [LN*DW-1:0] m_data  [DP];
    bit               m_valid [DP];

    function automatic int leff_of(input int len);
        return ((len == 0) || (len > DP)) ? DP : len;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [LN*DW-1:0] stage_word(input int k);
        logic [LN*DW-1:0] w;
        for (int l = 0; l < LN; l++) w[l*DW +: DW] = o_data[k][l];
        return w;
    endfunction

    function automatic logic [LN*DW-1:0] tap_word();
        logic [LN*DW-1:0] w;
        for (int l = 0; l < LN; l++) w[l*DW +: DW] = o_tap_data[l];
        return w;
    endfunction

    task automatic set_data(input logic [LN*DW-1:0] w);
        for (int l = 0; l < LN; l++) i_data[l] = w[l*DW +: DW];
    endtask

    task automatic model_clear();
        for (int k = 0; k < DP; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic [LN*DW-1:0] nd;
        bit               nv;
        int               le;
        le = leff_of(int'(i_len));
        if (i_flush) begin
            model_clear();
        end else if (i_en) begin
            if (i_mode) begin
                nd = m_data[le-1];
                nv = m_valid[le-1];
            end else begin
                for (int l = 0; l < LN; l++)
                    nd[l*DW +: DW] = i_lane_mask[l] ? i_data[l] : '0;
                nv = i_valid;
            end
            for (int k = DP - 1; k > 0; k--) begin
                m_data[k]  = m_data[k-1];
                m_valid[k] = m_valid[k-1];
            end
            m_data[0]  = nd;
            m_valid[0] = nv;
        end
    endtask

    task automatic check_model(input string tag);
        int le;
        int cnt;
        logic [DP-1:0] ev;
        le  = leff_of(int'(i_len));
        cnt = 0;
        for (int k = 0; k < DP; k++) begin
            ev[k] = m_valid[k];
            if (k < le && m_valid[k]) cnt++;
            chk($sformatf("%s stage%0d data", tag, k), 64'(stage_word(k)), 64'(m_data[k]));
        end
        chk({tag, " valid"}, 64'(o_valid), 64'(ev));
        chk({tag, " tap_data"}, 64'(tap_word()), 64'(m_data[le-1]));
        chk({tag, " tap_valid"}, 64'(o_tap_valid), 64'(m_valid[le-1]));
        chk({tag, " count"}, 64'(o_count), 64'(cnt));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        cycle("flush");
        i_flush = 1'b0;
    endtask

    typedef struct {
        logic [LN-1:0]    mask;
        logic [LN*DW-1:0] data;
        logic             vin;
        logic [LN*DW-1:0] exp0;
    } vec_t;

    vec_t tbl [5];
    logic [LN*DW-1:0] va, vb, vc;
    logic [LN*DW-1:0] rot_tap [3];
    logic [LN*DW-1:0] rot_s0  [3];

    initial begin
        tbl[0] = '{mask: 4'b0101, data: 32'h09090909, vin: 1'b1, exp0: 32'h00090009};
        tbl[1] = '{mask: 4'b1111, data: 32'h44332211, vin: 1'b1, exp0: 32'h44332211};
        tbl[2] = '{mask: 4'b0000, data: 32'hFFFFFFFF, vin: 1'b1, exp0: 32'h00000000};
        tbl[3] = '{mask: 4'b1010, data: 32'hA1B2C3D4, vin: 1'b0, exp0: 32'hA100C300};
        tbl[4] = '{mask: 4'b1000, data: 32'h12345678, vin: 1'b1, exp0: 32'h12000000};

        rst = 1'b0;
        i_en = 1'b0; i_flush = 1'b0; i_mode = 1'b0; i_len = LW'(5);
        i_valid = 1'b0; i_lane_mask = '1;
        set_data('0);
        model_clear();
        #12;
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset count", 64'(o_count), 64'd0);
        chk("reset tap", 64'(tap_word()), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Shift latency with Leff = 5.
        i_en = 1'b1; i_len = LW'(5); i_valid = 1'b1; i_lane_mask = 4'b1111;
        set_data(32'h04030201);
        cycle("lat issue");
        i_valid = 1'b0; set_data('0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("lat tap_valid %0d", i), 64'(o_tap_valid), 64'(i == 4));
            chk($sformatf("lat count %0d", i), 64'(o_count), 64'(i <= 4));
            if (i == 4) chk("lat tap_data", 64'(tap_word()), 64'h04030201);
            cycle("lat");
        end

        // Lane mask table.
        for (int t = 0; t < 5; t++) begin
            i_lane_mask = tbl[t].mask; set_data(tbl[t].data); i_valid = tbl[t].vin;
            cycle("mask");
            chk($sformatf("mask stage0 %0d", t), 64'(stage_word(0)), 64'(tbl[t].exp0));
            chk($sformatf("mask valid0 %0d", t), 64'(o_valid[0]), 64'(tbl[t].vin));
        end

        // Stall for three cycles while inputs wiggle.
        i_en = 1'b0; i_valid = 1'b1; set_data(32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall stage0", 64'(stage_word(0)), 64'h12000000);
        end

        // Rotate with Leff = 3: tap walks B,C,A; stage0 walks A,B,C.
        i_en = 1'b1; do_flush();
        i_len = LW'(3); i_mode = 1'b0; i_valid = 1'b1; i_lane_mask = '1;
        va = 32'hA0A1A2A3; vb = 32'hB0B1B2B3; vc = 32'hC0C1C2C3;
        set_data(va); cycle("rot load");
        set_data(vb); cycle("rot load");
        set_data(vc); cycle("rot load");
        chk("rot tap pre", 64'(tap_word()), 64'(va));
        rot_tap[0] = vb; rot_tap[1] = vc; rot_tap[2] = va;
        rot_s0[0]  = va; rot_s0[1]  = vb; rot_s0[2]  = vc;
        i_mode = 1'b1; i_valid = 1'b0; set_data('0);
        for (int i = 0; i < 6; i++) begin
            cycle("rot");
            chk($sformatf("rot tap %0d", i), 64'(tap_word()), 64'(rot_tap[i % 3]));
            chk($sformatf("rot stage0 %0d", i), 64'(stage_word(0)), 64'(rot_s0[i % 3]));
            chk($sformatf("rot count %0d", i), 64'(o_count), 64'd3);
        end

        // Flush beats enable on a full chain.
        i_mode = 1'b0; i_len = LW'(8); i_valid = 1'b1;
        for (int j = 0; j < DP; j++) begin
            set_data({4{8'(j + 16)}});
            cycle("fill");
        end
        chk("full count", 64'(o_count), 64'd8);
        i_flush = 1'b1; set_data(32'hFFFFFFFF);
        cycle("flush en");
        i_flush = 1'b0;
        chk("flush valid", 64'(o_valid), 64'd0);
        chk("flush stage0", 64'(stage_word(0)), 64'd0);
        chk("flush count", 64'(o_count), 64'd0);

        // Length clamp and same-cycle tap move.
        for (int j = 0; j < DP; j++) begin
            set_data({4{8'(j + 16)}});
            cycle("clamp fill");
        end
        i_len = LW'(0);  #1; chk("clamp len0", 64'(tap_word()), 64'h10101010);
        i_len = LW'(12); #1; chk("clamp len12", 64'(tap_word()), 64'h10101010);
        i_len = LW'(8);  set_data(32'h18181818);
        cycle("clamp step");
        i_len = LW'(2);  #1;
        chk("len 8->2 tap", 64'(tap_word()), 64'h17171717);
        chk("len 8->2 count", 64'(o_count), 64'd2);
        check_model("len2");

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            i_en        = ($urandom_range(0, 3) != 0);
            i_flush     = ($urandom_range(0, 29) == 0);
            i_mode      = ($urandom_range(0, 3) == 0);
            i_len       = LW'($urandom_range(0, 15));
            i_valid     = $urandom_range(0, 1) != 0;
            i_lane_mask = LN'($urandom);
            set_data($urandom);
            cycle("rand");
        end

        // Asynchronous reset mid-stream, checked before the next clock edge.
        i_en = 1'b1; i_flush = 1'b0; i_mode = 1'b0; i_valid = 1'b1; i_len = LW'(8);
        set_data(32'h55AA55AA); cycle("pre rst");
        cycle("pre rst");
        chk("pre rst busy", 64'(o_valid[0]), 64'd1);
        #2 rst = 1'b0;
        #1;
        model_clear();
        chk("async rst valid", 64'(o_valid), 64'd0);
        chk("async rst count", 64'(o_count), 64'd0);
        chk("async rst tap", 64'(tap_word()), 64'd0);
        chk("async rst stage0", 64'(stage_word(0)), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
